// File: rtl/tug_field.sv
// Tug-of-war playfield: a light walks between two players, first to 7 wins.
// Optional LFSR-driven computer player on the left side.
module tug_field #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LeftPress,
  input  logic       RightPress,
  input  logic       CpuEnable,
  input  logic [8:0] Difficulty,
  output logic [8:0] Leds,
  output logic [1:0] Winner,
  output logic [2:0] LeftScore,
  output logic [2:0] RightScore,
  output logic       GameOver
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [8:0] CENTRE = 9'b000010000;

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    OVER
  } state_t;

  state_t        state, state_n;
  logic [9:0]    lfsr;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0]    leds_n;
  logic [1:0]    winner_n;
  logic [2:0]    ls_n, rs_n;
  logic          over_n;
  logic          cpu_press, lp, rp;

  assign cpu_press = ({1'b0, Difficulty} > lfsr);
  assign lp = CpuEnable ? cpu_press : LeftPress;
  assign rp = RightPress;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= PLAY;
      lfsr       <= '0;
      cnt        <= '0;
      Leds       <= CENTRE;
      Winner     <= 2'b00;
      LeftScore  <= '0;
      RightScore <= '0;
      GameOver   <= 1'b0;
    end else begin
      state      <= state_n;
      lfsr       <= {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])};
      cnt        <= cnt_n;
      Leds       <= leds_n;
      Winner     <= winner_n;
      LeftScore  <= ls_n;
      RightScore <= rs_n;
      GameOver   <= over_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    leds_n   = Leds;
    winner_n = Winner;
    ls_n     = LeftScore;
    rs_n     = RightScore;
    over_n   = GameOver;
    case (state)
      PLAY: begin
        if (lp && !rp) begin
          if (Leds[8]) begin
            leds_n   = '0;
            winner_n = 2'b10;
            ls_n     = LeftScore + 3'd1;
            cnt_n    = '0;
            if (LeftScore == 3'd6) begin
              state_n = OVER;
              over_n  = 1'b1;
            end else begin
              state_n = HOLD;
            end
          end else begin
            leds_n = Leds << 1;
          end
        end else if (rp && !lp) begin
          if (Leds[0]) begin
            leds_n   = '0;
            winner_n = 2'b01;
            rs_n     = RightScore + 3'd1;
            cnt_n    = '0;
            if (RightScore == 3'd6) begin
              state_n = OVER;
              over_n  = 1'b1;
            end else begin
              state_n = HOLD;
            end
          end else begin
            leds_n = Leds >> 1;
          end
        end
      end
      HOLD: begin
        if (cnt == LAST) begin
          state_n = PLAY;
          leds_n  = CENTRE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      OVER: begin
        leds_n = '0;
      end
      default: begin
        state_n = PLAY;
        leds_n  = CENTRE;
      end
    endcase
  end

endmodule

// File: tb/tb_tug_field.sv
// Randomised bench for tug_field against a positional game model,
// plus directed rounds with literal expectations.
module tb_tug_field;

  localparam int HOLD = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       LeftPress, RightPress, CpuEnable;
  logic [8:0] Difficulty;
  logic [8:0] Leds;
  logic [1:0] Winner;
  logic [2:0] LeftScore, RightScore;
  logic       GameOver;

  tug_field #(.HOLD_CYCLES(HOLD)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .LeftPress(LeftPress),
    .RightPress(RightPress),
    .CpuEnable(CpuEnable),
    .Difficulty(Difficulty),
    .Leds(Leds),
    .Winner(Winner),
    .LeftScore(LeftScore),
    .RightScore(RightScore),
    .GameOver(GameOver)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // model: light position (-1 = dark), scores, remaining hold edges
  bit started = 0;
  int m_pos, m_ls, m_rs, m_win, m_hold, m_lfsr;
  bit m_over;
  bit m_lp, m_rp, m_cpu;

  always @(posedge Clock) begin
    cyc++;
    if (Reset) begin
      started = 1;
      m_pos = 4; m_ls = 0; m_rs = 0; m_win = 0;
      m_hold = 0; m_over = 0; m_lfsr = 0;
    end else if (started) begin
      m_cpu = (Difficulty > m_lfsr);
      m_lp = CpuEnable ? m_cpu : LeftPress;
      m_rp = RightPress;
      m_lfsr = ((m_lfsr << 1) |
                (1 - (((m_lfsr >> 9) & 1) ^ ((m_lfsr >> 6) & 1)))) & 1023;
      if (m_over) begin
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_pos = 4;
      end else if (m_lp && !m_rp) begin
        if (m_pos == 8) begin
          m_pos = -1; m_win = 2; m_ls++;
          if (m_ls == 7) m_over = 1; else m_hold = HOLD;
        end else m_pos++;
      end else if (m_rp && !m_lp) begin
        if (m_pos == 0) begin
          m_pos = -1; m_win = 1; m_rs++;
          if (m_rs == 7) m_over = 1; else m_hold = HOLD;
        end else m_pos--;
      end
    end
  end

  logic [8:0] e_leds;
  always @(negedge Clock) begin
    if (started) begin
      e_leds = (m_pos < 0) ? 9'h000 : 9'(1 << m_pos);
      tests++;
      if (Leds !== e_leds || Winner !== 2'(m_win) ||
          LeftScore !== 3'(m_ls) || RightScore !== 3'(m_rs) ||
          GameOver !== m_over) begin
        fails++;
        $display("FAIL model cyc %0d: got Leds=%h W=%b L=%0d R=%0d GO=%b, need Leds=%h W=%b L=%0d R=%0d GO=%b",
                 cyc, Leds, Winner, LeftScore, RightScore, GameOver,
                 e_leds, 2'(m_win), m_ls, m_rs, m_over);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, " leds"}, int'(Leds), 'h010);
    chk({name, " winner"}, int'(Winner), 0);
    chk({name, " lscore"}, int'(LeftScore), 0);
    chk({name, " rscore"}, int'(RightScore), 0);
    chk({name, " over"}, int'(GameOver), 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  int walk [4] = '{'h008, 'h004, 'h002, 'h001};

  initial begin
    Reset = 1'b1; LeftPress = 0; RightPress = 0;
    CpuEnable = 0; Difficulty = '0;
    repeat (2) @(negedge Clock);
    chk_reset("reset");
    Reset = 1'b0;

    // walk right four steps, then the winning press
    for (int i = 0; i < 4; i++) begin
      RightPress = 1;
      @(negedge Clock);
      chk("walk", int'(Leds), walk[i]);
    end
    @(negedge Clock);
    RightPress = 0;
    chk("win leds", int'(Leds), 0);
    chk("win winner", int'(Winner), 1);
    chk("win rscore", int'(RightScore), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("hold dark", int'(Leds), 0);
    end
    @(negedge Clock);
    chk("hold end", int'(Leds), 'h010);

    // simultaneous presses cancel
    LeftPress = 1; RightPress = 1;
    @(negedge Clock);
    LeftPress = 0; RightPress = 0;
    chk("tie leds", int'(Leds), 'h010);
    chk("tie rscore", int'(RightScore), 1);
    chk("tie lscore", int'(LeftScore), 0);

    // seven right wins end the game
    do_reset();
    RightPress = 1;
    repeat (68) @(negedge Clock);
    chk("over rscore", int'(RightScore), 7);
    chk("over flag", int'(GameOver), 1);
    chk("over leds", int'(Leds), 0);
    for (int i = 0; i < 20; i++) begin
      LeftPress = 1'($urandom);
      RightPress = 1'($urandom);
      @(negedge Clock);
    end
    LeftPress = 0; RightPress = 0;
    chk("frozen rscore", int'(RightScore), 7);
    chk("frozen lscore", int'(LeftScore), 0);
    Reset = 1'b1;
    @(negedge Clock);
    chk_reset("over reset");
    Reset = 1'b0;

    // computer never presses at difficulty 0
    CpuEnable = 1; Difficulty = 9'h000;
    for (int i = 0; i < 2000; i++) begin
      LeftPress = 1'($urandom);
      @(negedge Clock);
    end
    LeftPress = 0;
    chk("cpu0 leds", int'(Leds), 'h010);

    // max difficulty: LFSR from 0 goes 1,3,7 and cpu pushes each cycle
    Difficulty = 9'h1FF;
    do_reset();
    chk("lfsr0", m_lfsr, 0);
    @(negedge Clock);
    chk("lfsr1", m_lfsr, 'h001);
    @(negedge Clock);
    chk("lfsr2", m_lfsr, 'h003);
    @(negedge Clock);
    chk("lfsr3", m_lfsr, 'h007);
    chk("cpu max leds", int'(Leds), 'h080);
    for (int i = 0; i < 500; i++) begin
      RightPress = ($urandom_range(0, 2) != 0);
      @(negedge Clock);
    end
    RightPress = 0;

    // reset in the second hold cycle
    CpuEnable = 0;
    do_reset();
    RightPress = 1;
    repeat (5) @(negedge Clock);
    RightPress = 0;
    chk("pre-hold win", int'(Winner), 1);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk_reset("hold reset");
    RightPress = 1;
    @(negedge Clock);
    RightPress = 0;
    chk("post reset play", int'(Leds), 'h008);

    // fully random play
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) CpuEnable = 1'($urandom);
      if ($urandom_range(0, 31) == 0) Difficulty = 9'($urandom);
      LeftPress = ($urandom_range(0, 3) == 0);
      RightPress = ($urandom_range(0, 3) == 0);
      @(negedge Clock);
    end
    Reset = 0; LeftPress = 0; RightPress = 0;
    @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tug_field.md
TUG_FIELD -- requirements
Module: tug_field

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles the win display is held before the next round starts.
REQ-002 SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port LeftPress, input, 1 bit: one-cycle press pulse from the left player's button stage.
REQ-005 SHALL have port RightPress, input, 1 bit: one-cycle press pulse from the right player's button stage.
REQ-006 SHALL have port CpuEnable, input, 1 bit: 1 = the left side is driven by the computer player and LeftPress is ignored.
REQ-007 SHALL have port Difficulty, input, 9 bits: computer press threshold.
REQ-008 SHALL have port Leds, output, 9 bits: playfield, one-hot light position, index 4 = centre.
REQ-009 SHALL have port Winner, output, 2 bits: 00 none, 10 left won the last round, 01 right won the last round.
REQ-010 SHALL have port LeftScore, output, 3 bits: left rounds won.
REQ-011 SHALL have port RightScore, output, 3 bits: right rounds won.
REQ-012 SHALL have port GameOver, output, 1 bit: high once either score reaches 7.

Function
REQ-013 SHALL hold a 10-bit LFSR with XNOR feedback of bits 9 and 6 (x^10+x^7+1), shifting into bit 0 every cycle in all states.
REQ-014 SHALL form the computer press as CpuPress = ({1'b0,Difficulty} > lfsr), using the registered LFSR value of the current cycle.
REQ-015 SHALL form the effective left press as Lp = CpuEnable ? CpuPress : LeftPress, and the effective right press as Rp = RightPress.
REQ-016 SHALL implement three states: PLAY, HOLD and OVER.
REQ-017 In PLAY, Lp & ~Rp SHALL move the light one index toward 8, and Rp & ~Lp SHALL move it one index toward 0.
REQ-018 In PLAY, Lp & Rp, or neither press, SHALL leave the light unchanged.
REQ-019 A move SHALL be visible on Leds in the cycle after the edge that samples the press (1-cycle latency).
REQ-020 In PLAY, a light at index 8 with Lp & ~Rp SHALL be a left win; a light at index 0 with Rp & ~Lp SHALL be a right win.
REQ-021 On a win, on the same edge: Leds SHALL go to 0, Winner SHALL show the winning side, the winner's score SHALL increment, and the hold counter SHALL load 0.
REQ-022 After a win, the next state SHALL be OVER if the new score equals 7, otherwise HOLD.
REQ-023 In HOLD, the counter SHALL increment each cycle; when it equals HOLD_CYCLES-1, the next state SHALL be PLAY with Leds = 9'b000010000.
REQ-024 Winner SHALL persist until the next round's win and SHALL be cleared only by reset.
REQ-025 In HOLD and OVER, all presses SHALL be ignored.
REQ-026 OVER SHALL be terminal until Reset: Leds = 0, GameOver = 1, scores frozen.
REQ-027 Scores SHALL never exceed 7 and SHALL never wrap to 0.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 While Reset = 1 at an edge, the block SHALL enter PLAY with Leds = 9'b000010000, Winner = 00, LeftScore = 0, RightScore = 0, GameOver = 0, lfsr = 0 and hold counter = 0.
REQ-030 Reset SHALL take priority over every press and state, including in mid-HOLD and in OVER.

Verification
REQ-031 Reset, then CpuEnable = 0 and 4 RightPress pulses on separate cycles -> Leds walks 0x010, 0x008, 0x004, 0x002, 0x001, one step per cycle after each pulse.
REQ-032 From Leds = 0x001, a 5th RightPress -> next cycle Leds = 0, Winner = 01, RightScore = 1; the state is HOLD for 4 cycles, then Leds = 0x010.
REQ-033 LeftPress and RightPress high in the same cycle, with the light at centre -> Leds stays 0x010, no score change.
REQ-034 A right win repeated 7 times -> RightScore = 7 and GameOver = 1; further presses change nothing; Reset -> all outputs return to their reset values.
REQ-035 CpuEnable = 1, Difficulty = 0 -> no left movement over 2000 cycles. CpuEnable = 1, Difficulty = 9'h1FF -> left moves on every cycle where lfsr < 511; check the LFSR sequence from 0 against a reference model: 0x001, 0x003, 0x007 ...
REQ-036 Assert Reset during HOLD (2nd hold cycle) -> next cycle the state is PLAY at centre, with scores and Winner cleared.
